// File: rtl/fetch_controller.sv
// Instruction fetch sequencer for the core front end.
// Owns the fetch PC and keeps at most one word request outstanding to
// instruction memory. Each fetched word is handed to decode together with
// its PC. A branch redirect reloads the PC and squashes any wrong-path
// response that is still in flight.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic [31:0] pc
);

  // REQ: request pending, WAIT: response outstanding, HOLD: word offered to decode
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] req_pc_r;
  logic [31:0] req_pc_s;
  logic [31:0] inst_r;
  logic [31:0] inst_s;
  logic [31:0] inst_pc_r;
  logic [31:0] inst_pc_s;
  logic        kill_r;
  logic        kill_s;
  logic [31:0] target_s;
  logic        req_fire_s;
  logic        unused_s;

  // Redirect targets are forced onto a word boundary; the low bits carry no meaning.
  assign target_s   = {branch_target[31:2], 2'b00};
  assign unused_s   = ^branch_target[1:0];
  assign req_fire_s = mem_req_valid & mem_req_ready;

  assign mem_req_valid = (state_r == ST_REQ) & ~reset;
  assign mem_req_addr  = pc_r;
  assign pc            = pc_r;
  assign inst_valid    = (state_r == ST_HOLD) & ~reset;
  assign instruction   = inst_r;
  assign inst_pc       = inst_pc_r;

  // Next-state logic: a redirect overrides every normal transition.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    req_pc_s  = req_pc_r;
    inst_s    = inst_r;
    inst_pc_s = inst_pc_r;
    kill_s    = kill_r;
    case (state_r)
      ST_REQ: begin
        if (branch_taken) begin
          pc_s = target_s;
          if (req_fire_s) begin
            // The accepted request still carries the old address: mark it wrong-path.
            req_pc_s = pc_r;
            state_s  = ST_WAIT;
            kill_s   = 1'b1;
          end else begin
            state_s = ST_REQ;
          end
        end else if (req_fire_s) begin
          req_pc_s = pc_r;
          pc_s     = pc_r + 32'd4;
          state_s  = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (branch_taken) begin
          pc_s = target_s;
          if (mem_rsp_valid) begin
            kill_s  = 1'b0;
            state_s = ST_REQ;
          end else begin
            kill_s  = 1'b1;
            state_s = ST_WAIT;
          end
        end else if (mem_rsp_valid) begin
          if (kill_r) begin
            kill_s  = 1'b0;
            state_s = ST_REQ;
          end else begin
            inst_s    = mem_rsp_data;
            inst_pc_s = req_pc_r;
            state_s   = ST_HOLD;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (branch_taken) begin
          // The held word is wrong-path; decode is flushed alongside this redirect.
          pc_s    = target_s;
          state_s = ST_REQ;
        end else if (inst_ready) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_REQ;
        kill_s  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset that abandons any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_REQ;
      pc_r      <= RESET_PC;
      req_pc_r  <= 32'h0000_0000;
      inst_r    <= 32'h0000_0000;
      inst_pc_r <= 32'h0000_0000;
      kill_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      req_pc_r  <= req_pc_s;
      inst_r    <= inst_s;
      inst_pc_r <= inst_pc_s;
      kill_r    <= kill_s;
    end
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences instruction fetch for the core front end. Owns the fetch PC. Issues one word request at a time to instruction memory over a valid/ready request channel and a valid-only response channel. Presents each fetched word with its PC to decode over a valid/ready handshake. Handles branch redirects, including squashing of in-flight wrong-path responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset (bits [1:0] must be 0)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
branch_taken  input  1  redirect request from execute, single-cycle pulse
branch_target  input  32  redirect address, sampled when branch_taken=1
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  32  word-aligned fetch address
mem_rsp_valid  input  1  response data valid, exactly one per accepted request, >=1 cycle after acceptance
mem_rsp_data  input  32  instruction word
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode accepts instruction
instruction  output  32  fetched instruction
inst_pc  output  32  PC of instruction
pc  output  32  current fetch PC (next address to request)

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- Registers: pc_reg, req_pc, inst_reg, inst_pc_reg, kill flag, state.
- States: REQ, WAIT, HOLD.
- Reset (sync, active-high):
  - state=REQ, pc_reg=RESET_PC, kill=0, inst_reg=0, inst_pc_reg=0.
  - mem_req_valid and inst_valid are forced 0 during any cycle with reset=1.
  - Reset mid-transaction abandons everything. A memory response arriving after reset while in REQ is ignored.
- Outputs:
  - mem_req_valid = (state==REQ) & !reset.
  - mem_req_addr = pc_reg.
  - pc = pc_reg.
  - inst_valid = (state==HOLD) & !reset.
  - instruction = inst_reg; inst_pc = inst_pc_reg.
- REQ state:
  - On mem_req_valid & mem_req_ready: req_pc<=pc_reg, pc_reg<=pc_reg+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), state<=WAIT.
  - Address is held stable while unaccepted, except when changed by a redirect.
- WAIT state:
  - On mem_rsp_valid with kill=0: inst_reg<=mem_rsp_data, inst_pc_reg<=req_pc, state<=HOLD.
  - On mem_rsp_valid with kill=1: drop data, kill<=0, state<=REQ.
- HOLD state:
  - On inst_ready: state<=REQ. The next request issues the cycle after the handoff.
  - instruction and inst_pc stay stable while inst_valid=1 and inst_ready=0.
- mem_rsp_valid outside WAIT is ignored.
- Redirect (branch_taken=1) has priority over all normal transitions:
  - pc_reg <= {branch_target[31:2],2'b00}.
  - REQ, no handshake this cycle: stay REQ; next cycle requests the target.
  - REQ, handshake this cycle: the request carries the old address and is wrong-path. state<=WAIT, kill<=1. pc_reg is not incremented.
  - WAIT, no response this cycle: stay WAIT, kill<=1.
  - WAIT, response this cycle: drop the response, kill<=0, state<=REQ.
  - HOLD: discard the held instruction. state<=REQ; inst_valid is 0 next cycle. A simultaneous inst_ready also discards the held instruction; decode must not consume it (the pipeline flush covers this).
- At most one outstanding memory request at all times.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with zero-wait memory and decode.

Test Plan:
- Reset release, RESET_PC=0, memory ready=1 with 1-cycle response:
  - mem_req_addr sequence 0,4,8.
  - inst_pc 0,4,8 with matching data.
  - inst_valid high exactly one cycle per instruction while inst_ready=1.
- Backpressure: inst_ready=0 for 5 cycles while in HOLD -> instruction and inst_pc stable, no new mem request; inst_ready=1 -> next request at inst_pc+4.
- Redirect while in WAIT:
  - branch_taken with target 0x100 before the response arrives.
  - The old response is dropped; inst_valid never asserts for it.
  - Next request addr=0x100.
  - Variant with the response in the same cycle as the branch -> same result.
- Redirect in the same cycle as a request handshake at 0x20, target 0x203 -> the response for 0x20 is dropped, next request addr=0x200.
- Redirect while in HOLD with inst_ready=1 the same cycle -> inst_valid=0 next cycle, next request addr=target.
- Wrap and reset:
  - With pc=0xFFFF_FFFC, the fetch completes and the next request addr=0.
  - Asserting reset while in WAIT, then a late mem_rsp_valid after release, gives mem_req_addr=RESET_PC, the late response is ignored, and inst_valid=0.
